prog_loader: RTL

Parametrised program/data loader for the single-cycle core. It accepts a valid/ready word stream from a host or bench driver and writes instruction and data memory through their write ports, which replaces hierarchical backdoor pokes. It holds the core in reset until a START command arrives and can return the core to reset on HALT. It sits between the external load port and the core's `InstMem`/`dmem` instances inside `TopLevel`.

---
 rtl/prog_loader.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - host word-stream loader for instruction/data memory with core reset control
module prog_loader #(
  parameter int XLEN       = 32,
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256,
  parameter int IA_W       = $clog2(IMEM_DEPTH),
  parameter int DA_W       = $clog2(DMEM_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_data,
  output logic            imem_we,
  output logic [IA_W-1:0] imem_addr,
  output logic [XLEN-1:0] imem_wdata,
  output logic            dmem_we,
  output logic [DA_W-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic            core_rst,
  output logic            running,
  output logic            err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_I = 2'd1,
    WR_D = 2'd2,
    RUN  = 2'd3
  } state_t;

  localparam logic [1:0] OP_WR_IMEM = 2'b00;
  localparam logic [1:0] OP_WR_DMEM = 2'b01;
  localparam logic [1:0] OP_START   = 2'b10;
  localparam logic [1:0] OP_HALT    = 2'b11;

  // Depth limits widened by one bit so a 32768-word memory still compares correctly.
  localparam logic [16:0] IMEM_LIM = 17'(IMEM_DEPTH);
  localparam logic [16:0] DMEM_LIM = 17'(DMEM_DEPTH);

  state_t            state_q, state_d;
  // Running word address; 16 bits so base+count never wraps (max 32767+32767).
  logic [15:0]       addr_q, addr_d;
  logic [14:0]       rem_q, rem_d;
  logic              err_q, err_d;
  logic              ready_q;
  logic              imem_we_q, imem_we_d;
  logic [IA_W-1:0]   imem_addr_q, imem_addr_d;
  logic [XLEN-1:0]   imem_wdata_q, imem_wdata_d;
  logic              dmem_we_q, dmem_we_d;
  logic [DA_W-1:0]   dmem_addr_q, dmem_addr_d;
  logic [XLEN-1:0]   dmem_wdata_q, dmem_wdata_d;

  logic              beat;
  logic [1:0]        hdr_op;
  logic [14:0]       hdr_base;
  logic [14:0]       hdr_cnt;
  logic              imem_in_range;
  logic              dmem_in_range;

  // Header fields come from the low 32 bits only; wider builds ignore the rest.
  assign beat     = in_valid && ready_q;
  assign hdr_op   = in_data[31:30];
  assign hdr_base = in_data[29:15];
  assign hdr_cnt  = in_data[14:0];

  assign imem_in_range = ({1'b0, addr_q} < IMEM_LIM);
  assign dmem_in_range = ({1'b0, addr_q} < DMEM_LIM);

  // Next-state, address/count bookkeeping and write-port staging for the next cycle.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    err_d        = err_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    dmem_we_d    = 1'b0;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;

    if (beat) begin
      case (state_q)
        IDLE: begin
          case (hdr_op)
            OP_WR_IMEM: begin
              if (hdr_cnt != 15'd0) begin
                state_d = WR_I;
                addr_d  = {1'b0, hdr_base};
                rem_d   = hdr_cnt;
              end
            end
            OP_WR_DMEM: begin
              if (hdr_cnt != 15'd0) begin
                state_d = WR_D;
                addr_d  = {1'b0, hdr_base};
                rem_d   = hdr_cnt;
              end
            end
            OP_START: state_d = RUN;
            default:  state_d = IDLE;
          endcase
        end

        WR_I: begin
          if (imem_in_range) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = addr_q[IA_W-1:0];
            imem_wdata_d = in_data;
          end else begin
            err_d = 1'b1;
          end
          addr_d = addr_q + 16'd1;
          rem_d  = rem_q - 15'd1;
          if (rem_q == 15'd1) state_d = IDLE;
        end

        WR_D: begin
          if (dmem_in_range) begin
            dmem_we_d    = 1'b1;
            dmem_addr_d  = addr_q[DA_W-1:0];
            dmem_wdata_d = in_data;
          end else begin
            err_d = 1'b1;
          end
          addr_d = addr_q + 16'd1;
          rem_d  = rem_q - 15'd1;
          if (rem_q == 15'd1) state_d = IDLE;
        end

        RUN: begin
          // Loads while the core runs are refused; no payload follows them.
          case (hdr_op)
            OP_HALT:    state_d = IDLE;
            OP_WR_IMEM: err_d   = 1'b1;
            OP_WR_DMEM: err_d   = 1'b1;
            default:    state_d = RUN;
          endcase
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers; reset aborts any transfer in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      err_q        <= 1'b0;
      ready_q      <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      err_q        <= err_d;
      ready_q      <= 1'b1;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
    end
  end

  assign in_ready   = ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign core_rst   = (state_q != RUN);
  assign running    = (state_q == RUN);
  assign err        = err_q;

endmodule
